alu_arbiter: RTL and testbench

//   Shares one combinational ALU between two requesters, e.g. the integer

---
 rtl/alu_arbiter.sv | 170 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional grant locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CTRL_W   = 4,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
`ifdef ALU_ARB_LOCK_EN
  input  logic              req0_lock,
  input  logic              req1_lock,
`endif
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              grant_valid,
  output logic              grant_id
);

  if (LOCK_MAX < 1) begin : g_lock_max_chk
    $error("LOCK_MAX must be at least 1");
  end

  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             last_grant_q, last_grant_d;
  logic             elig0, elig1;
  logic             gnt_v, gnt_id;

`ifdef ALU_ARB_LOCK_EN
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             gnt_lock;
  int unsigned      cnt_inc;
`endif

  // A slot being drained this cycle counts as free, so drain+refill is one cycle.
  always_comb begin
    elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);
`ifdef ALU_ARB_LOCK_EN
    if (state_q == LOCK0) elig1 = 1'b0;
    if (state_q == LOCK1) elig0 = 1'b0;
`endif
    gnt_v  = elig0 | elig1;
    gnt_id = (elig0 & elig1) ? ~last_grant_q : elig1;
  end

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (gnt_v) begin
      if (gnt_id) begin
        alu_a       = req1_a;
        alu_b       = req1_b;
        alu_control = req1_ctrl;
      end else begin
        alu_a       = req0_a;
        alu_b       = req0_b;
        alu_control = req0_ctrl;
      end
    end
  end

  always_comb begin
    rsp0_valid_d  = rsp0_valid_q & ~rsp0_ready;
    rsp1_valid_d  = rsp1_valid_q & ~rsp1_ready;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    last_grant_d  = last_grant_q;
    if (gnt_v) begin
      last_grant_d = gnt_id;
      if (gnt_id) begin
        rsp1_valid_d  = 1'b1;
        rsp1_result_d = alu_result;
      end else begin
        rsp0_valid_d  = 1'b1;
        rsp0_result_d = alu_result;
      end
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // lock_cnt counts grants already made under the current lock, including the entry grant.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    gnt_lock   = gnt_id ? req1_lock : req0_lock;
    cnt_inc    = int'(lock_cnt_q) + 1;
    if (gnt_v) begin
      case (state_q)
        ARB: begin
          if (gnt_lock) begin
            state_d    = gnt_id ? LOCK1 : LOCK0;
            lock_cnt_d = CNT_W'(1);
          end
        end
        default: begin
          if (!gnt_lock || cnt_inc >= LOCK_MAX) begin
            state_d    = ARB;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = CNT_W'(cnt_inc);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign req0_ready  = gnt_v & ~gnt_id;
  assign req1_ready  = gnt_v & gnt_id;
  assign grant_valid = gnt_v;
  assign grant_id    = gnt_id;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; the lock scenario runs when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CTRL_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic              req0_lock, req1_lock;
  logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0]  rsp0_result, rsp1_result;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
  logic [CTRL_W-1:0] alu_control;
  logic              grant_valid, grant_id;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  // External ALU model: ADD / SUB, zero for other codes.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_ctrl = '0; req1_ctrl = '0; req0_lock = 0; req1_lock = 0;
    rsp0_ready = 0; rsp1_ready = 0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_grant_valid", 32'(grant_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);

    // 1: single request from port 0
    @(negedge clk);
    rst_n = 1; req0_valid = 1; req0_a = 5; req0_b = 10; req0_ctrl = 4'b0000;
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 1);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 10);
    @(negedge clk);
    req0_valid = 0; rsp0_ready = 1;
    #1;
    chk("t1_rsp0_valid", 32'(rsp0_valid), 1);
    chk("t1_rsp0_result", rsp0_result, 15);
    chk("t1_idle_grant", 32'(grant_valid), 0);
    chk("t1_idle_alu_b", alu_b, 0);
    @(negedge clk);
    rsp0_ready = 0;
    req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 2; req1_ctrl = 4'b0000;
    #1;
    chk("drain_rsp0_valid", 32'(rsp0_valid), 0);
    chk("drain_rsp0_result", rsp0_result, 15);
    chk("wrap_grant_id", 32'(grant_id), 1);
    @(negedge clk);
    req1_valid = 0;
    #1;
    chk("wrap_rsp1_valid", 32'(rsp1_valid), 1);
    chk("wrap_rsp1_result", rsp1_result, 1);

    // 2: contention from reset, alternating grants
    @(negedge clk);
    rst_n = 0; #1; rst_n = 1;
    req0_valid = 1; req0_a = 12; req0_b = 7; req0_ctrl = 4'b0001;
    req1_valid = 1; req1_a = 5;  req1_b = 10; req1_ctrl = 4'b0000;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    chk("t2_gid0", 32'(grant_id), 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t2_gid", 32'(grant_id), 32'(i % 2));
      if ((i % 2) == 1) begin
        chk("t2_rsp0_valid", 32'(rsp0_valid), 1);
        chk("t2_rsp0_result", rsp0_result, 5);
      end else begin
        chk("t2_rsp1_valid", 32'(rsp1_valid), 1);
        chk("t2_rsp1_result", rsp1_result, 15);
      end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("t2_rsp1_last", rsp1_result, 15);

    // 3/4: backpressure on port 0, then drain+refill
    @(negedge clk);
    rsp0_ready = 0; req0_valid = 1; req0_a = 5; req0_b = 10; req0_ctrl = 4'b0000;
    #1;
    chk("t3_fill_req0_ready", 32'(req0_ready), 1);
    @(negedge clk);
    req1_valid = 1; req1_a = 3; req1_b = 4; req1_ctrl = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_req0_ready", 32'(req0_ready), 0);
      chk("t3_gid", 32'(grant_id), 1);
      chk("t3_rsp0_hold", rsp0_result, 15);
      if (k > 0) chk("t3_rsp1_result", rsp1_result, 7);
      @(negedge clk);
    end
    rsp0_ready = 1; req0_a = 7; req0_b = 1;
    #1;
    chk("t3_release_gid", 32'(grant_id), 0);
    chk("t3_release_ready", 32'(req0_ready), 1);
    chk("t4_consumed_valid", 32'(rsp0_valid), 1);
    chk("t4_consumed_result", rsp0_result, 15);
    @(negedge clk);
    rsp0_ready = 0; req0_valid = 0; rsp1_ready = 0;
    #1;
    chk("t4_refill_valid", 32'(rsp0_valid), 1);
    chk("t4_refill_result", rsp0_result, 8);
    @(negedge clk);
    req1_valid = 0;
    #1;
    chk("t5_pre_rsp1_valid", 32'(rsp1_valid), 1);
    chk("t5_pre_rsp1_result", rsp1_result, 7);

    // 5: reset while both response slots are full
    rst_n = 0;
    #1;
    chk("t5_rsp0_valid", 32'(rsp0_valid), 0);
    chk("t5_rsp1_valid", 32'(rsp1_valid), 0);
    chk("t5_rsp0_result", rsp0_result, 0);
    chk("t5_rsp1_result", rsp1_result, 0);
    req0_valid = 1; req0_a = 5; req0_b = 10; req0_ctrl = 4'b0000;
    req1_valid = 1; req1_a = 12; req1_b = 7; req1_ctrl = 4'b0001;
    rsp0_ready = 1; rsp1_ready = 1;
    rst_n = 1;
    #1;
    chk("t5_first_gid", 32'(grant_id), 0);
    chk("t5_req0_ready", 32'(req0_ready), 1);
    chk("t5_req1_ready", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("t5_after_result", rsp0_result, 15);

`ifdef ALU_ARB_LOCK_EN
    // 6: port 1 locks for LOCK_MAX grants while port 0 waits
    @(negedge clk);
    req1_valid = 1; req1_lock = 1; req0_valid = 1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("t6_gid", 32'(grant_id), (g < 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; req1_lock = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
